testip_axil_slave_regs: RTL and testbench

//  AXI4-Lite slave register file: the responder end of the S00_AXI interface that the

---
 rtl/testip_axil_slave_regs.sv | 186 ++++++++++++++++++
 tb/tb_testip_axil_slave_regs.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/testip_axil_slave_regs.sv
// AXI4-Lite slave register file: NUM_REGS 32-bit registers with byte-strobe writes,
// independent read/write channels and a flat export of all register contents.
module testip_axil_slave_regs #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic {W_COLLECT, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t               wstate;
  rstate_t               rstate;
  logic                  aw_held;
  logic                  w_held;
  logic [IDX_W-1:0]      aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_inputs;

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // A held beat takes priority; otherwise the beat handshaking this cycle is used directly
  assign aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
  assign wr_idx  = aw_held ? aw_idx : S_AXI_AWADDR[ADDR_WIDTH-1:2];
  assign wr_data = w_held ? w_data : S_AXI_WDATA;
  assign wr_strb = w_held ? w_strb : S_AXI_WSTRB;
  assign commit  = (wstate == W_COLLECT) & (aw_held | aw_hs) & (w_held | w_hs);
  assign wr_ok   = 32'(wr_idx) < NUM_REGS;
  assign rd_idx  = S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign rd_ok   = 32'(rd_idx) < NUM_REGS;

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(rd_idx) == i) rd_data = regs[i];
    end
  end

  // Register storage; out-of-range writes never reach it
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && wr_ok) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (32'(wr_idx) == i) begin
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  // Write channel: collect AW and W independently, then respond
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wstate        <= W_COLLECT;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx        <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
    end else begin
      case (wstate)
        W_COLLECT: begin
          if (commit) begin
            wstate        <= W_RESP;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b1;
            S_AXI_BRESP   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            if (aw_hs) begin
              aw_held <= 1'b1;
              aw_idx  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
              w_held <= 1'b1;
              w_data <= S_AXI_WDATA;
              w_strb <= S_AXI_WSTRB;
            end
            S_AXI_AWREADY <= !(aw_held | aw_hs);
            S_AXI_WREADY  <= !(w_held | w_hs);
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            wstate        <= W_COLLECT;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
          end
        end
        default: wstate <= W_COLLECT;
      endcase
    end
  end

  // Read channel: one outstanding read, data captured on the AR handshake
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rstate        <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            rstate        <= R_DATA;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RDATA   <= rd_ok ? rd_data : '0;
            S_AXI_RRESP   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rstate        <= R_IDLE;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_testip_axil_slave_regs.sv
// Self-checking bench for testip_axil_slave_regs: scoreboard of expected B/R responses
// driven from a bench-side register model.
module tb_testip_axil_slave_regs;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW-1:0]     awaddr = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [DW-1:0]     wdata = '0;
  logic [DW/8-1:0]   wstrb = '0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic [AW-1:0]     araddr = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready = 1'b0;
  logic [NR*DW-1:0]  regs_o;

  always #5 clk = ~clk;

  testip_axil_slave_regs #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .regs_o(regs_o)
  );

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] model [NR];
  exp_t        bq [$];
  exp_t        rq [$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] r;
    for (int i = 0; i < int'(NR); i++) r[i*32 +: 32] = model[i];
    return r;
  endfunction

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int hold);
    exp_t e;
    int   idx;
    int   n;
    logic aw_done, w_done, aw_now, w_now;
    idx    = int'(addr[4:2]);
    e.resp = (idx < int'(NR)) ? 2'b00 : 2'b10;
    e.data = '0;
    bq.push_back(e);
    if (idx < int'(NR))
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    awaddr = addr; wdata = data; wstrb = strb;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      awvalid = !aw_done && (n >= aw_dly);
      wvalid  = !w_done && (n >= w_dly);
      aw_now  = awvalid && awready;
      w_now   = wvalid && wready;
      @(posedge clk); #1;
      if (aw_now) aw_done = 1'b1;
      if (w_now) w_done = 1'b1;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_handshake", {aw_done, w_done}, 2'b11);
    check("bvalid_latency", bvalid, 1'b1);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      check("bvalid_hold", bvalid, 1'b1);
      check("bresp_hold", bresp, e.resp);
      check("awwready_hold", {awready, wready}, 2'b00);
    end
    e = bq.pop_front();
    check("bresp", bresp, e.resp);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_clear", bvalid, 1'b0);
    check("awwready_back", {awready, wready}, 2'b11);
    check("regs_o", regs_o, model_flat());
  endtask

  task automatic axi_read(input logic [4:0] addr, input int hold);
    exp_t e;
    int   idx;
    int   n;
    logic done, ar_now;
    idx    = int'(addr[4:2]);
    e.resp = (idx < int'(NR)) ? 2'b00 : 2'b10;
    e.data = (idx < int'(NR)) ? model[idx] : 32'h0;
    rq.push_back(e);
    araddr = addr; arvalid = 1'b1; done = 1'b0; n = 0;
    while (!done && n < 50) begin
      ar_now = arready;
      @(posedge clk); #1;
      if (ar_now) done = 1'b1;
      n++;
    end
    arvalid = 1'b0;
    check("rd_handshake", done, 1'b1);
    check("rvalid_latency", rvalid, 1'b1);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      check("rvalid_hold", rvalid, 1'b1);
      check("rdata_hold", rdata, e.data);
      check("arready_hold", arready, 1'b0);
    end
    e = rq.pop_front();
    check("rdata", rdata, e.data);
    check("rresp", rresp, e.resp);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("rvalid_clear", rvalid, 1'b0);
    check("arready_back", arready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(NR); i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp}, '0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_regs_o", regs_o, '0);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", {awready, wready, arready}, 3'b000);
    @(posedge clk); #1;
    check("ready_after_release", {awready, wready, arready}, 3'b111);

    // Basic writes and readback
    for (int i = 0; i < 4; i++) axi_write(5'(i*4), 32'(i+1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(5'(i*4), 0);

    // Byte strobes
    axi_write(5'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_write(5'h04, 32'h0000_00AA, 4'b0001, 0, 0, 0);
    axi_read(5'h04, 0);
    axi_write(5'h0A, 32'h1234_5678, 4'b1010, 0, 0, 0);
    axi_read(5'h08, 0);

    // AW/W ordering
    axi_write(5'h0C, 32'hDEAD_BEEF, 4'hF, 3, 0, 0);
    axi_write(5'h00, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
    axi_write(5'h08, 32'h0BAD_CAFE, 4'hF, 0, 2, 0);
    axi_read(5'h0C, 0);
    axi_read(5'h00, 0);
    axi_read(5'h08, 0);

    // Out of range
    axi_write(5'h10, 32'h5555_5555, 4'hF, 0, 0, 0);
    axi_write(5'h1C, 32'h6666_6666, 4'hF, 1, 0, 0);
    axi_read(5'h10, 0);
    axi_read(5'h1F, 0);

    // Backpressure on responses
    axi_write(5'h04, 32'h0BAD_F00D, 4'hF, 0, 0, 10);
    axi_read(5'h04, 10);

    // Reset with both responses pending
    awaddr = 5'h00; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 5'h04; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model[0] = 32'h77;
    check("pend_valids", {bvalid, rvalid}, 2'b11);
    check("pend_regs_o", regs_o, model_flat());
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < int'(NR); i++) model[i] = '0;
    check("mid_rst_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp}, '0);
    check("mid_rst_rdata", rdata, 32'h0);
    check("mid_rst_regs_o", regs_o, model_flat());
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("ready_before_edge2", {awready, wready, arready}, 3'b000);
    @(posedge clk); #1;
    check("ready_after_release2", {awready, wready, arready}, 3'b111);
    axi_read(5'h00, 0);
    axi_write(5'h08, 32'hA5A5_5A5A, 4'b0110, 0, 1, 0);
    axi_read(5'h08, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
